// File: rtl/halt_monitor_pkg.sv
// Shared types and constants for the Hack run-to-halt monitor.
package halt_monitor_pkg;

    typedef enum logic [1:0] {
        ARMED,
        RUN,
        DUMP,
        DONE
    } state_e;

    localparam logic [1:0] W_STATUS = 2'd0;
    localparam logic [1:0] W_CYCLES = 2'd1;
    localparam logic [1:0] W_RAM0   = 2'd2;

    localparam int unsigned ST_HALTED  = 0;
    localparam int unsigned ST_TIMEOUT = 1;

endpackage

// File: rtl/halt_report_tx.sv
// Three-word valid/ready serializer for the halt result record.
module halt_report_tx
    import halt_monitor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_status,
    input  logic [15:0] i_cycles,
    input  logic [15:0] i_ram0,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [15:0] o_data,
    output logic        o_done
);
    logic       r_valid;
    logic [1:0] r_idx;

    // Word sources are held stable by the top for the whole dump.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_idx   <= W_STATUS;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_idx   <= W_STATUS;
        end else if (r_valid && i_ready) begin
            if (r_idx == W_RAM0) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    always_comb begin
        o_data = '0;
        if (r_valid) begin
            unique case (r_idx)
                W_STATUS: o_data = i_status;
                W_CYCLES: o_data = i_cycles;
                W_RAM0:   o_data = i_ram0;
                default:  o_data = '0;
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_done  = r_valid && i_ready && (r_idx == W_RAM0);

endmodule

// File: rtl/halt_monitor.sv
// Counts enabled CPU cycles, detects the halt idiom or a timeout, freezes the
// CPU and streams status, cycle count and RAM[0] to the host.
module halt_monitor
    import halt_monitor_pkg::*;
#(
    parameter int unsigned MAX_CYCLES    = 1000,
    parameter int unsigned STABLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [15:0] pc,
    input  logic [15:0] ram0,
    output logic        cpu_hold,
    output logic        halted,
    output logic        timeout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);
    localparam int unsigned RepW = $clog2(STABLE_CYCLES + 1);

    state_e           r_state,   w_state_d;
    logic [15:0]      r_prev_pc, w_prev_pc_d;
    logic [CNT_W-1:0] r_cycles,  w_cycles_d;
    logic [RepW-1:0]  r_rep,     w_rep_d;
    logic [15:0]      r_ram0_q,  w_ram0_d;
    logic             r_halted,  w_halted_d;
    logic             r_timeout, w_timeout_d;

    logic             w_load;
    logic             w_tx_done;
    logic [CNT_W-1:0] w_cycles_inc;
    logic [RepW:0]    w_rep_inc;
    logic             w_pc_same;
    logic [15:0]      w_status;
    logic [15:0]      w_cycles16;

    assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + CNT_W'(1);
    assign w_rep_inc    = {1'b0, r_rep} + (RepW + 1)'(1);
    assign w_pc_same    = (pc == r_prev_pc);

    always_comb begin
        w_state_d   = r_state;
        w_prev_pc_d = r_prev_pc;
        w_cycles_d  = r_cycles;
        w_rep_d     = r_rep;
        w_ram0_d    = r_ram0_q;
        w_halted_d  = r_halted;
        w_timeout_d = r_timeout;
        w_load      = 1'b0;

        unique case (r_state)
            ARMED: begin
                if (cpu_en) begin
                    w_cycles_d  = CNT_W'(1);
                    w_prev_pc_d = pc;
                    if (MAX_CYCLES == 1) begin
                        w_timeout_d = 1'b1;
                        w_ram0_d    = ram0;
                        w_load      = 1'b1;
                        w_state_d   = DUMP;
                    end else begin
                        w_state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cpu_en) begin
                    w_cycles_d  = w_cycles_inc;
                    w_prev_pc_d = pc;
                    w_rep_d     = w_pc_same ? w_rep_inc[RepW-1:0] : '0;
                    // Halt takes priority when both conditions land on one edge.
                    if (w_pc_same && (w_rep_inc >= (RepW + 1)'(STABLE_CYCLES))) begin
                        w_halted_d = 1'b1;
                        w_ram0_d   = ram0;
                        w_load     = 1'b1;
                        w_state_d  = DUMP;
                    end else if (w_cycles_inc == CNT_W'(MAX_CYCLES)) begin
                        w_timeout_d = 1'b1;
                        w_ram0_d    = ram0;
                        w_load      = 1'b1;
                        w_state_d   = DUMP;
                    end
                end
            end
            DUMP: begin
                if (w_tx_done) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_state_d = DONE;
            end
            default: begin
                w_state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ARMED;
            r_prev_pc <= '0;
            r_cycles  <= '0;
            r_rep     <= '0;
            r_ram0_q  <= '0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_prev_pc <= w_prev_pc_d;
            r_cycles  <= w_cycles_d;
            r_rep     <= w_rep_d;
            r_ram0_q  <= w_ram0_d;
            r_halted  <= w_halted_d;
            r_timeout <= w_timeout_d;
        end
    end

    always_comb begin
        w_status             = '0;
        w_status[ST_HALTED]  = r_halted;
        w_status[ST_TIMEOUT] = r_timeout;
    end

    assign w_cycles16 = 16'(r_cycles);

    halt_report_tx u_tx (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_status (w_status),
        .i_cycles (w_cycles16),
        .i_ram0   (r_ram0_q),
        .i_ready  (out_ready),
        .o_valid  (out_valid),
        .o_data   (out_data),
        .o_done   (w_tx_done)
    );

    assign cpu_hold = (r_state == DUMP) || (r_state == DONE);
    assign halted   = r_halted;
    assign timeout  = r_timeout;

endmodule

// File: doc/halt_monitor.md
# halt_monitor

- Synthesizable hardware counterpart of the Hack computer's run-to-halt check.
- Sits beside `Computer`, consuming its program counter and RAM[0]:
  - counts executed cycles;
  - detects the Hack halt idiom (PC stops changing, i.e. `@END; 0;JMP`) or a cycle-limit timeout;
  - freezes the CPU;
  - streams a 3-word result record (status, cycle count, RAM[0]) over a valid/ready port to a host or UART bridge.

## Interface

Parameters:
- `MAX_CYCLES`, 1000: timeout limit in counted cycles; must be ≤ 2^`CNT_W`−1.
- `STABLE_CYCLES`, 1: consecutive equal-PC comparisons required to declare halt; ≥ 1.
- `CNT_W`, 16: cycle counter width.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low. Reset is asynchronous and active-low; the port keeps the codebase name `reset`.
- `cpu_en` in 1: CPU advanced this cycle; only enabled edges are counted and compared.
- `pc` in 16: CPU program counter, `computer.pc`.
- `ram0` in 16: live value of RAM[0].
- `cpu_hold` out 1: freeze request to the CPU, gating its clock enable.
- `halted` out 1: halt detected (sticky until reset).
- `timeout` out 1: `MAX_CYCLES` reached without halt (sticky until reset).
- `out_valid` out 1: result word available.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out 16: result word.

## Operation

States:
- `ARMED`: no previous PC sample yet.
- `RUN`
- `DUMP`: emitting words, index 0..2.
- `DONE`

Registered state:
- `prev_pc` (16)
- `cycles` (`CNT_W`): counted edges, saturating at all-ones.
- `rep` (repeat counter, sized for `STABLE_CYCLES`)
- `ram0_q` (16)
- `idx` (2)

Transitions (evaluated only on edges with `cpu_en`=1 in `ARMED`/`RUN`):
- `ARMED`:
  - `cycles`←1, `prev_pc`←`pc`, go to `RUN`.
  - If `MAX_CYCLES`=1, set `timeout` instead and go to `DUMP`.
- `RUN`:
  - `cycles`←`cycles`+1 (saturating).
  - If `pc`==`prev_pc`, `rep`←`rep`+1; else `rep`←0.
  - `prev_pc`←`pc`.
  - **Halt:** if `rep`+1 ≥ `STABLE_CYCLES` with equal PC → `halted`←1, `ram0_q`←`ram0`, `idx`←0, go to `DUMP`.
  - **Timeout:** else if the new `cycles` == `MAX_CYCLES` → `timeout`←1, `ram0_q`←`ram0`, go to `DUMP`.
  - If halt and timeout fall on the same edge, halt wins: `halted`=1, `timeout`=0.
- `DUMP`: `out_valid`=1.
  - `out_data` by index:
    - `idx`=0: status `{14'b0, timeout, halted}`.
    - `idx`=1: `cycles` (zero-extended/truncated to 16).
    - `idx`=2: `ram0_q`.
  - When `out_valid`&`out_ready`, `idx`←`idx`+1.
  - Acceptance at `idx`=2 → `DONE`.
- `DONE`: `out_valid`=0, all outputs held.

Holds and inputs:
- `cpu_hold`=1 in `DUMP` and `DONE`.
- `cpu_en` and `pc` are ignored outside `ARMED`/`RUN`.
- `cpu_en`=0 in `RUN`: nothing changes, including `rep`.

Reset values (asserted asynchronously, any state, including mid-`DUMP`):
- state=`ARMED`
- `cycles`=0, `rep`=0, `idx`=0
- `prev_pc`=0, `ram0_q`=0
- `halted`=0, `timeout`=0, `cpu_hold`=0
- `out_valid`=0, `out_data`=0

## Timing

Detection and freeze:
- Detection is registered. `halted`/`timeout`, `cpu_hold` and `out_valid` (word 0) all rise in the cycle after the detecting edge.
- `cpu_hold` reaches the CPU one cycle late. One extra CPU cycle after detection is tolerated; it is neither counted nor sampled.

Result port:
- Word throughput: 1 word/cycle when `out_ready` is held high. The record completes 3 cycles after `DUMP` entry.
- Stall: `out_valid`/`out_data` stay stable while `out_ready`=0. `out_valid` never drops before acceptance.
- `out_data` is 0 whenever `out_valid`=0.

Reset release:
- Deassertion is asynchronous. The first counted edge is the first enabled rising edge after release.

## Structure

- Package `halt_monitor_pkg` holds:
  - the state enum (`ARMED`, `RUN`, `DUMP`, `DONE`);
  - the word-index constants (`W_STATUS`=0, `W_CYCLES`=1, `W_RAM0`=2);
  - the status bit positions (`ST_HALTED`=0, `ST_TIMEOUT`=1).
- One natural sub-module: `halt_report_tx`, the 3-word valid/ready serializer.
  - It is loaded with status, cycles and `ram0_q` on `DUMP` entry.
  - It signals `done` on the last acceptance.
- Detection and counting stay in the top.

## Test plan

- **Halt loop:** `cpu_en`=1, `out_ready`=1, `pc` = 0,1,2,3,3 → `halted`=1 after the 5th edge, `cpu_hold`=1, words 0x0001, 5, RAM[0] value (e.g. 0x0007), then `out_valid`=0.
- **Timeout:** `pc` increments forever, `MAX_CYCLES`=1000 → `timeout`=1, `halted`=0, words 0x0002, 1000, ram0.
- **Stall:** as the halt loop, with `out_ready`=0 for 4 cycles after `DUMP` entry → word 0x0001 held stable for 4 cycles; then 3 words in 3 consecutive cycles.
- **Enable gating:** `STABLE_CYCLES`=2, `pc` 5,5,6,6,6, with `cpu_en`=0 inserted between the repeats → no halt until two enabled equal comparisons; cycles counts only enabled edges (5).
- **Tie:** `MAX_CYCLES`=4, `pc` 0,1,2,2 → `halted`=1, `timeout`=0, cycles=4.
- **Reset mid-dump:** assert `reset` low after word 1 is accepted → all outputs 0 immediately. After release, a new halt run reports fresh counts.
